vga_scan: RTL and testbench

Raster scan generator and pixel output stage for the VGA text display. Sits directly downstream of the character buffer: it drives the buffer's read address (character row/column plus in-glyph offsets), samples the returned lit/out-of-bounds bits, and produces registered RGB and sync signals for the VGA connector. Default timing is 640x480 at 60 Hz with one pixel per enabled clock.

---
 rtl/vga_scan.sv | 127 ++++++++++++
 tb/tb_vga_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// Purpose : raster scan generator and pixel output stage for the VGA text display.
// Latency : one enabled cycle from read address to registered RGB/sync/frame_start.
// Backpressure: none; pix_en is the only pacing input. When it is low, counters and outputs hold.
//
// Ports:
//   clk, rst (async, active-low)  clock and reset
//   pix_en                        pixel strobe; all state advances only when high
//   read_hchar/vchar/hoffset/voffset  character buffer read address, combinational from the counters
//   read_lit, out_of_bounds       character buffer response for the current address
//   vga_r/g/b, vga_hsync, vga_vsync   registered connector outputs (syncs active-low)
//   frame_start                   one-cycle (enabled) pulse aligned with output pixel (0,0)
//
// Optional feature macro: VGA_SCAN_BORDER_EN. When it is defined, active pixels flagged
// out_of_bounds are drawn in blue (12'h00F). Otherwise they are drawn in p_bg_color.
module vga_scan #(
  parameter int          p_h_active = 640,
  parameter int          p_h_front  = 16,
  parameter int          p_h_sync   = 96,
  parameter int          p_h_back   = 48,
  parameter int          p_v_active = 480,
  parameter int          p_v_front  = 10,
  parameter int          p_v_sync   = 2,
  parameter int          p_v_back   = 33,
  parameter logic [11:0] p_fg_color = 12'hFFF,
  parameter logic [11:0] p_bg_color = 12'h000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [6:0] read_hchar,
  output logic [5:0] read_vchar,
  output logic [2:0] read_hoffset,
  output logic [2:0] read_voffset,
  input  logic       read_lit,
  input  logic       out_of_bounds,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = p_h_active + p_h_front + p_h_sync + p_h_back;
  localparam int V_TOTAL = p_v_active + p_v_front + p_v_sync + p_v_back;

  // All timing boundaries are pre-cast to the counter width so every compare is 10 bits.
  localparam logic [9:0] H_ACT      = 10'(p_h_active);
  localparam logic [9:0] H_SYNC_BEG = 10'(p_h_active + p_h_front);
  localparam logic [9:0] H_SYNC_END = 10'(p_h_active + p_h_front + p_h_sync);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT      = 10'(p_v_active);
  localparam logic [9:0] V_SYNC_BEG = 10'(p_v_active + p_v_front);
  localparam logic [9:0] V_SYNC_END = 10'(p_v_active + p_v_front + p_v_sync);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [11:0] BORDER_COLOR = 12'h00F;
`else
  // Same select path as the bordered build; this constant makes out_of_bounds a no-op.
  localparam logic [11:0] BORDER_COLOR = p_bg_color;
`endif

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;
  logic        at_origin;
  logic [11:0] color;

  // Read address is a pure function of the counters, valid during blanking too.
  assign read_hchar   = hcount[9:3];
  assign read_vchar   = vcount[8:3];
  assign read_hoffset = hcount[2:0];
  assign read_voffset = vcount[2:0];

  always_comb begin
    active    = (hcount < H_ACT) && (vcount < V_ACT);
    hsync_n   = !((hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END));
    vsync_n   = !((vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END));
    at_origin = (hcount == 10'd0) && (vcount == 10'd0);
    color     = 12'h000;
    if (active) begin
      if (out_of_bounds) begin
        color = BORDER_COLOR;
      end else if (read_lit) begin
        color = p_fg_color;
      end else begin
        color = p_bg_color;
      end
    end
  end

  // Counters and the single output stage share one enable, so the outputs always
  // describe the pixel whose address was presented on the previous enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= 10'd0;
        if (vcount == V_LAST) begin
          vcount <= 10'd0;
        end else begin
          vcount <= vcount + 10'd1;
        end
      end else begin
        hcount <= hcount + 10'd1;
      end
      vga_r       <= color[11:8];
      vga_g       <= color[7:4];
      vga_b       <= color[3:0];
      vga_hsync   <= hsync_n;
      vga_vsync   <= vsync_n;
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan using a reduced raster (158 x 25) so whole frames fit in a short run.
module tb_vga_scan;

  localparam int HA = 128, HF = 8, HS = 12, HB = 10;
  localparam int VA = 16,  VF = 2, VS = 3,  VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] FG = 12'hEA5;
  localparam logic [11:0] BG = 12'h132;
`ifdef VGA_SCAN_BORDER_EN
  localparam logic [11:0] BRD = 12'h00F;
`else
  localparam logic [11:0] BRD = BG;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [6:0] read_hchar;
  logic [5:0] read_vchar;
  logic [2:0] read_hoffset;
  logic [2:0] read_voffset;
  logic       read_lit;
  logic       out_of_bounds;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, frame_start;

  always #5 clk = ~clk;

  vga_scan #(
    .p_h_active(HA), .p_h_front(HF), .p_h_sync(HS), .p_h_back(HB),
    .p_v_active(VA), .p_v_front(VF), .p_v_sync(VS), .p_v_back(VB),
    .p_fg_color(FG), .p_bg_color(BG)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .read_hchar(read_hchar), .read_vchar(read_vchar),
    .read_hoffset(read_hoffset), .read_voffset(read_voffset),
    .read_lit(read_lit), .out_of_bounds(out_of_bounds),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the raster is just a running pixel index within the frame.
  int          pidx;
  logic [11:0] e_rgb;
  bit          e_hs, e_vs, e_fs;
  bit          tie_lit = 0;
  bit          tie_oob = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic void model_reset();
    pidx  = 0;
    e_rgb = 12'h000;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_fs  = 1'b0;
  endfunction

  function automatic void model_edge(input bit lit, input bit oob);
    int h = pidx % HT;
    int v = pidx / HT;
    bit act = (h < HA) && (v < VA);
    if (!act)      e_rgb = 12'h000;
    else if (oob)  e_rgb = BRD;
    else if (lit)  e_rgb = FG;
    else           e_rgb = BG;
    e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
    e_fs = (pidx == 0);
    pidx = (pidx + 1) % FRAME;
  endfunction

  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  // One clock: drive inputs at the falling edge, check the address, then check
  // the registered outputs 1 time unit after the rising edge.
  task automatic step(input bit en, input bit lit, input bit oob);
    bit l, o;
    @(negedge clk);
    pix_en = en;
    #0;
    l = tie_lit ? read_hoffset[0] : lit;
    o = tie_oob ? (read_hchar >= 7'd8) : oob;
    read_lit = l;
    out_of_bounds = o;
    chk("hchar",   read_hchar,   (pidx % HT) >> 3);
    chk("hoffset", read_hoffset, (pidx % HT) & 7);
    chk("vchar",   read_vchar,   ((pidx / HT) >> 3) & 63);
    chk("voffset", read_voffset, (pidx / HT) & 7);
    @(posedge clk);
    if (en && rst === 1'b1) model_edge(l, o);
    #1;
    chk("rgb",         rgb(),       e_rgb);
    chk("hsync",       vga_hsync,   e_hs);
    chk("vsync",       vga_vsync,   e_vs);
    chk("frame_start", frame_start, e_fs);
  endtask

  task automatic advance_to(input int target, input string nm);
    for (int i = 0; i < FRAME + 2 && pidx != target; i++) step(1'b1, 1'b0, 1'b0);
    if (pidx != target) fail_now(nm);
  endtask

  typedef struct {
    bit          en;
    bit          lit;
    bit          oob;
    logic [11:0] rgb;
    bit          fs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_first, hs_second, hs_low0, vs_low, vs_first, fs_next, prev_hs;
    int fall_a, fall_b;

    // Pixels 0..5 after reset; pix_en=0 rows must hold the previous outputs.
    vecs[0] = '{1'b1, 1'b1, 1'b0, FG,  1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, FG,  1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, BG,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, BRD, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, BRD, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, BRD, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, FG,  1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, BG,  1'b0};

    rst = 1'b0;
    pix_en = 1'b1;
    read_lit = 1'b0;
    out_of_bounds = 1'b0;
    model_reset();

    // Reset held with pix_en high: outputs pinned at reset values.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("rst_rgb", rgb(), 0);
      chk("rst_hsync", vga_hsync, 1);
      chk("rst_vsync", vga_vsync, 1);
      chk("rst_fs", frame_start, 0);
    end
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].en, vecs[i].lit, vecs[i].oob);
      chk($sformatf("vec%0d_rgb", i), rgb(), vecs[i].rgb);
      chk($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
    end

    // Address/pipeline: read_lit follows read_hoffset[0].
    tie_lit = 1;
    advance_to(13, "adv13");
    chk("pix12_rgb", rgb(), BG);
    chk("h13_hchar", read_hchar, 1);
    chk("h13_hoffset", read_hoffset, 5);
    step(1'b1, 1'b0, 1'b0);
    chk("pix13_rgb", rgb(), FG);
    tie_lit = 0;

    // Out-of-bounds region beyond character column 7.
    tie_oob = 1;
    advance_to(2 * HT + 100, "adv_col100");
    step(1'b1, 1'b0, 1'b0);
    chk("col100_rgb", rgb(), BRD);
    advance_to(2 * HT + 140, "adv_col140");
    step(1'b1, 1'b0, 1'b0);
    chk("col140_rgb", rgb(), 0);
    tie_oob = 0;

    // Sync timing over one full frame, indices relative to output pixel (0,0).
    advance_to(0, "adv_frame");
    hs_first = -1; hs_second = -1; hs_low0 = 0; vs_low = 0; vs_first = -1; fs_next = -1;
    prev_hs = 1;
    for (int n = 0; n <= FRAME; n++) begin
      step(1'b1, $urandom_range(0, 1), 1'b0);
      if (!vga_hsync && prev_hs == 1) begin
        if (hs_first < 0) hs_first = n;
        else if (hs_second < 0) hs_second = n;
      end
      if (!vga_hsync && n < HT) hs_low0++;
      if (!vga_vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = n;
      end
      if (n > 0 && frame_start && fs_next < 0) fs_next = n;
      prev_hs = vga_hsync;
    end
    chk("hsync_start", hs_first, HA + HF);
    chk("hsync_width", hs_low0, HS);
    chk("line_period", hs_second - hs_first, HT);
    chk("vsync_lines", vs_low, VS * HT);
    chk("vsync_start", vs_first, (VA + VF) * HT);
    chk("frame_period", fs_next, FRAME);

    // pix_en toggling: line period doubles in clocks, model checks every hold cycle.
    fall_a = -1; fall_b = -1; prev_hs = vga_hsync;
    for (int c = 0; c < 8 * HT && fall_b < 0; c++) begin
      step(c[0] == 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
      if (!vga_hsync && prev_hs == 1) begin
        if (fall_a < 0) fall_a = c;
        else fall_b = c;
      end
      prev_hs = vga_hsync;
    end
    if (fall_b < 0) fail_now("toggle_line");
    else chk("toggle_line_period", fall_b - fall_a, 2 * HT);

    // Mid-frame asynchronous reset, asserted between clock edges.
    advance_to(10 * HT + 50, "adv_mid");
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb(), 0);
    chk("mid_rst_hsync", vga_hsync, 1);
    chk("mid_rst_vsync", vga_vsync, 1);
    chk("mid_rst_fs", frame_start, 0);
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("mid_rel_fs", frame_start, 1);
    chk("mid_rel_rgb", rgb(), FG);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
